// File: rtl/led_mode_select_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_mode_select_pkg
// Brief   : Shared mode encodings and helpers for the LED mode selector and
//           the LED control block that consumes its mode word.
// Revision: 1.0 - initial release
// ============================================================================
package led_mode_select_pkg;

  // Width of the mode word handed to the LED control block
  localparam int MODE_W = 4;

  // Mode encodings shared with the LED control block
  localparam logic [MODE_W-1:0] MODE_OFF    = 4'd0;
  localparam logic [MODE_W-1:0] MODE_FLASH  = 4'd1;
  localparam logic [MODE_W-1:0] MODE_RUN    = 4'd2;
  localparam logic [MODE_W-1:0] MODE_BREATH = 4'd3;

  // Idle level of an active-low push-button
  localparam logic KEY_RELEASED = 1'b1;

  // What the mode register does in a given cycle
  typedef enum logic [1:0] {
    ACT_KEEP = 2'd0,
    ACT_NEXT = 2'd1,
    ACT_PREV = 2'd2,
    ACT_OFF  = 2'd3
  } mode_act_e;

  // One step forward or backward, wrapping between 0 and max
  function automatic logic [MODE_W-1:0] mode_step(
    input logic [MODE_W-1:0] cur,
    input logic [MODE_W-1:0] max,
    input logic              up
  );
    logic [MODE_W-1:0] res;
    if (up) begin
      res = (cur == max) ? MODE_OFF : cur + 1'b1;
    end else begin
      res = (cur == MODE_OFF) ? max : cur - 1'b1;
    end
    return res;
  endfunction

endpackage : led_mode_select_pkg
`default_nettype wire

// File: rtl/led_mode_select_key_debounce.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce
// Brief   : Two-flop synchroniser, stability counter and falling-edge detect
//           for one active-low push-button.
// Revision: 1.0 - initial release
// ============================================================================
module key_debounce
  import led_mode_select_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic press_pulse
);

  localparam int              CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Bring the asynchronous pin into the clock domain; idles at released level
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{KEY_RELEASED}};
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYC cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (sync_q[1] != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Pulse coincides with the first cycle the debounced level reads pressed
    press_d = state_q & ~state_d;
  end

  // Debounced state, stability counter and registered press strobe
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KEY_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign key_state   = state_q;
  assign press_pulse = press_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/led_mode_select.sv
`default_nettype none
// ============================================================================
// Module  : led_mode_select
// Brief   : Steps the LED mode word forward/backward from two push-buttons,
//           forces mode off on a long press of the next key, and strobes
//           mode_chg whenever the word changes.
// Revision: 1.0 - initial release
// ============================================================================
module led_mode_select
  import led_mode_select_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter int MODE_MAX     = 3
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              key_next,
  input  logic              key_prev,
  output logic [MODE_W-1:0] cntl,
  output logic              mode_chg
);

  localparam int               HOLD_W    = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [MODE_W-1:0] MODE_TOP  = MODE_W'(MODE_MAX);

  logic next_state, next_press;
  logic prev_state_unused, prev_press;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_done_q, long_done_d;
  logic              long_fire;
  mode_act_e         act;
  logic [MODE_W-1:0] cntl_q, cntl_d;
  logic              mode_chg_q, mode_chg_d;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_next_key (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .key_in      (key_next),
    .key_state   (next_state),
    .press_pulse (next_press)
  );

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_prev_key (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .key_in      (key_prev),
    .key_state   (prev_state_unused),
    .press_pulse (prev_press)
  );

  // Hold timer for the next key; one forced-off event per continuous hold
  always_comb begin
    hold_d      = hold_q;
    long_done_d = long_done_q;
    long_fire   = 1'b0;
    if (next_state == KEY_RELEASED) begin
      hold_d      = '0;
      long_done_d = 1'b0;
    end else begin
      if (hold_q != HOLD_LAST) begin
        hold_d = hold_q + 1'b1;
      end
      if ((hold_q == HOLD_LAST) && !long_done_q) begin
        long_fire   = 1'b1;
        long_done_d = 1'b1;
      end
    end
  end

  // Arbitrate key events: long press wins, simultaneous short presses cancel
  always_comb begin
    act = ACT_KEEP;
    if (long_fire) begin
      act = ACT_OFF;
    end else if (next_press && prev_press) begin
      act = ACT_KEEP;
    end else if (next_press) begin
      act = ACT_NEXT;
    end else if (prev_press) begin
      act = ACT_PREV;
    end
  end

  // Next mode word and change strobe
  always_comb begin
    cntl_d = cntl_q;
    unique case (act)
      ACT_NEXT: cntl_d = mode_step(cntl_q, MODE_TOP, 1'b1);
      ACT_PREV: cntl_d = mode_step(cntl_q, MODE_TOP, 1'b0);
      ACT_OFF:  cntl_d = MODE_OFF;
      default:  cntl_d = cntl_q;
    endcase
    mode_chg_d = (cntl_d != cntl_q);
  end

  // Mode register, strobe and hold-timer state
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      long_done_q <= 1'b0;
      cntl_q      <= MODE_OFF;
      mode_chg_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      cntl_q      <= cntl_d;
      mode_chg_q  <= mode_chg_d;
    end
  end

  assign cntl     = cntl_q;
  assign mode_chg = mode_chg_q;

endmodule : led_mode_select
`default_nettype wire

// File: tb/tb_led_mode_select.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_mode_select
// Brief   : Self-checking bench for led_mode_select (short debounce/long-press
//           parameters): vector table plus hand-written corner sequences,
//           with every mode_chg pulse checked against an expected-value queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_mode_select;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int MMAX = 3;

  logic       sys_clk;
  logic       rst_n;
  logic       key_next;
  logic       key_prev;
  logic [3:0] cntl;
  logic       mode_chg;

  led_mode_select #(
    .DEBOUNCE_CYC (DEB),
    .LONG_CYC     (LONG),
    .MODE_MAX     (MMAX)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .key_next (key_next),
    .key_prev (key_prev),
    .cntl     (cntl),
    .mode_chg (mode_chg)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // act: 0 next press, 1 prev press, 2 both keys together, 3 short low glitch on next
  typedef struct {
    int act;
    int hold;
    int rel;
    int exp_cntl;
    int exp_pulses;
  } vec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  int         pulses = 0;
  int         cyc = 0;
  int         pulse_t0 = 0;
  int         pulse_t1 = 0;
  logic [3:0] last_cntl = 4'd0;
  logic [3:0] exp_q[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act_v, input int exp_v);
    n_cmp++;
    if (act_v != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  // Scoreboard: each mode_chg pulse must match the next expected mode word
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      last_cntl = cntl;
    end else begin
      if (mode_chg) begin
        pulses++;
        pulse_t1 = pulse_t0;
        pulse_t0 = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pulse: cntl=%0d, no change expected (t=%0t)", cntl, $time);
        end else begin
          chk("pulse_cntl", int'(cntl), int'(exp_q.pop_front()));
        end
      end else if (cntl !== last_cntl) begin
        n_cmp++;
        n_err++;
        $display("FAIL silent_change: cntl %0d -> %0d without mode_chg (t=%0t)", last_cntl, cntl, $time);
      end
      last_cntl = cntl;
    end
  end

  task automatic apply(input vec_t v);
    int p0;
    p0 = pulses;
    if (v.exp_pulses > 0) exp_q.push_back(4'(v.exp_cntl));
    @(negedge sys_clk);
    case (v.act)
      0:       key_next = 1'b0;
      1:       key_prev = 1'b0;
      2:       begin key_next = 1'b0; key_prev = 1'b0; end
      default: key_next = 1'b0;
    endcase
    repeat (v.hold) @(negedge sys_clk);
    key_next = 1'b1;
    key_prev = 1'b1;
    repeat (v.rel) @(negedge sys_clk);
    chk("vec_cntl", int'(cntl), v.exp_cntl);
    chk("vec_pulses", pulses - p0, v.exp_pulses);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   p0;
    int   lat;
    int   gap;

    vecs[0] = '{act: 0, hold: 10, rel: 10, exp_cntl: 1, exp_pulses: 1};
    vecs[1] = '{act: 0, hold: 10, rel: 10, exp_cntl: 2, exp_pulses: 1};
    vecs[2] = '{act: 0, hold: 10, rel: 10, exp_cntl: 3, exp_pulses: 1};
    vecs[3] = '{act: 0, hold: 10, rel: 10, exp_cntl: 0, exp_pulses: 1};
    vecs[4] = '{act: 1, hold: 10, rel: 10, exp_cntl: 3, exp_pulses: 1};
    vecs[5] = '{act: 1, hold: 10, rel: 10, exp_cntl: 2, exp_pulses: 1};
    vecs[6] = '{act: 3, hold: 3,  rel: 10, exp_cntl: 2, exp_pulses: 0};
    vecs[7] = '{act: 2, hold: 10, rel: 10, exp_cntl: 2, exp_pulses: 0};

    // Reset state
    rst_n    = 1'b0;
    key_next = 1'b1;
    key_prev = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset_cntl", int'(cntl), 0);
    chk("reset_mode_chg", int'(mode_chg), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Table: wrap forward, wrap backward, glitch rejection, simultaneous presses
    for (int i = 0; i < 8; i++) apply(vecs[i]);

    // Bounce on next for 12 cycles, then a clean hold: one increment, 7-cycle latency
    p0 = pulses;
    exp_q.push_back(4'd3);
    for (int i = 0; i < 3; i++) begin
      key_next = 1'b0;
      repeat (2) @(negedge sys_clk);
      key_next = 1'b1;
      repeat (2) @(negedge sys_clk);
    end
    key_next = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge sys_clk);
      #1;
      if (cntl == 4'd3) begin
        lat = n;
        break;
      end
    end
    chk("bounce_latency", lat, 2 + DEB + 1);
    @(negedge sys_clk);
    key_next = 1'b1;
    repeat (12) @(negedge sys_clk);
    chk("bounce_cntl", int'(cntl), 3);
    chk("bounce_pulses", pulses - p0, 1);

    // Walk to mode 1 (3 -> 0 -> 1)
    v = '{act: 0, hold: 10, rel: 10, exp_cntl: 0, exp_pulses: 1};
    apply(v);
    v = '{act: 0, hold: 10, rel: 10, exp_cntl: 1, exp_pulses: 1};
    apply(v);

    // Long press from mode 1: increment to 2, then forced to 0, release does nothing
    p0 = pulses;
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd0);
    key_next = 1'b0;
    repeat (40) @(negedge sys_clk);
    key_next = 1'b1;
    repeat (15) @(negedge sys_clk);
    chk("long_cntl", int'(cntl), 0);
    chk("long_pulses", pulses - p0, 2);
    gap = pulse_t0 - pulse_t1;
    chk("long_gap_in_range", int'(gap >= LONG - 2 && gap <= LONG), 1);

    // Reset in the middle of a hold, key still held when reset is released
    exp_q.push_back(4'd1);
    key_next = 1'b0;
    repeat (12) @(negedge sys_clk);
    chk("prehold_cntl", int'(cntl), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_cntl", int'(cntl), 0);
    chk("async_reset_mode_chg", int'(mode_chg), 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    p0 = pulses;
    exp_q.push_back(4'd1);
    repeat (15) @(negedge sys_clk);
    key_next = 1'b1;
    repeat (12) @(negedge sys_clk);
    chk("post_reset_cntl", int'(cntl), 1);
    chk("post_reset_pulses", pulses - p0, 1);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_led_mode_select
`default_nettype wire
